// File: rtl/ioctl_pkg.sv
// Shared definitions for the HPS ioctl upload responder: FSM states,
// the fill byte returned outside the region and the ioctl address width.
`timescale 1ns/1ps
package ioctl_pkg;

   localparam int IOCTL_AW = 25;
   localparam logic [7:0] FILL_BYTE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LAT  = 2'd2
   } upl_state_e;

   // True when a byte offset falls inside the served region; compared at the
   // full ioctl width so high address bits are never silently dropped.
   function automatic logic addr_in_region(input logic [IOCTL_AW-1:0] offset,
                                           input logic [IOCTL_AW-1:0] length);
      return (offset < length);
   endfunction

endpackage

// File: rtl/upload_responder.sv
// Answers HPS upload reads for a core RAM window: fetches one byte through an
// arbitrated RAM read port and stalls the HPS with ioctl_wait until it is valid.
`timescale 1ns/1ps
module upload_responder
   import ioctl_pkg::*;
#(
   parameter int             AW         = 12,
   parameter logic [AW-1:0]  START_ADDR = 12'h000,
   parameter int             LENGTH     = 64,
   parameter logic [7:0]     INDEX      = 8'd3,
   parameter int             RAM_LAT    = 1
) (
   input  logic                clk,
   input  logic                RESET_N,
   input  logic                ioctl_upload,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_rd,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   output logic [7:0]          ioctl_din,
   output logic                ioctl_wait,
   output logic [AW-1:0]       ram_addr,
   output logic                ram_rd,
   input  logic                ram_grant,
   input  logic [7:0]          ram_q,
   output logic                overrun
);

   localparam logic [IOCTL_AW-1:0] REGION_LEN = IOCTL_AW'(LENGTH);
   localparam logic [1:0]          LAT_LOAD   = 2'(RAM_LAT - 1);

   upl_state_e    r_state;
   logic [7:0]    r_din;
   logic          r_wait;
   logic [AW-1:0] r_ram_addr;
   logic          r_ram_rd;
   logic [1:0]    r_cnt;
   logic          r_overrun;
   logic          r_upload_d;

   upl_state_e    w_state_nx;
   logic [7:0]    w_din_nx;
   logic          w_wait_nx;
   logic [AW-1:0] w_ram_addr_nx;
   logic          w_ram_rd_nx;
   logic [1:0]    w_cnt_nx;
   logic          w_overrun_nx;
   logic          w_sel;
   logic          w_rise;

   // Next-state and next-output logic; an upload drop while busy aborts the fetch.
   always_comb begin
      w_state_nx    = r_state;
      w_din_nx      = r_din;
      w_wait_nx     = r_wait;
      w_ram_addr_nx = r_ram_addr;
      w_ram_rd_nx   = r_ram_rd;
      w_cnt_nx      = r_cnt;
      w_overrun_nx  = r_overrun;
      w_sel  = ioctl_rd & ioctl_upload & (ioctl_index == INDEX);
      w_rise = ioctl_upload & ~r_upload_d;

      case (r_state)
         ST_IDLE: begin
            if (w_sel) begin
               if (addr_in_region(ioctl_addr, REGION_LEN)) begin
                  w_state_nx    = ST_REQ;
                  w_wait_nx     = 1'b1;
                  w_ram_rd_nx   = 1'b1;
                  w_ram_addr_nx = START_ADDR + ioctl_addr[AW-1:0];
               end else begin
                  w_din_nx = FILL_BYTE;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!ioctl_upload) begin
               w_state_nx  = ST_IDLE;
               w_ram_rd_nx = 1'b0;
               w_wait_nx   = 1'b0;
            end else if (ram_grant) begin
               w_state_nx  = ST_LAT;
               w_ram_rd_nx = 1'b0;
               w_cnt_nx    = LAT_LOAD;
            end else begin
               w_state_nx = ST_REQ;
            end
         end
         ST_LAT: begin
            if (!ioctl_upload) begin
               w_state_nx = ST_IDLE;
               w_wait_nx  = 1'b0;
            end else if (r_cnt == 2'd0) begin
               w_state_nx = ST_IDLE;
               w_din_nx   = ram_q;
               w_wait_nx  = 1'b0;
            end else begin
               w_cnt_nx = r_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nx  = ST_IDLE;
            w_ram_rd_nx = 1'b0;
            w_wait_nx   = 1'b0;
         end
      endcase

      // A fresh upload session clears the overrun flag.
      if (w_rise) begin
         w_overrun_nx = 1'b0;
      end else if (w_sel && (r_state != ST_IDLE)) begin
         w_overrun_nx = 1'b1;
      end else begin
         w_overrun_nx = r_overrun;
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_IDLE;
         r_din      <= 8'h00;
         r_wait     <= 1'b0;
         r_ram_addr <= '0;
         r_ram_rd   <= 1'b0;
         r_cnt      <= 2'd0;
         r_overrun  <= 1'b0;
         r_upload_d <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_din      <= w_din_nx;
         r_wait     <= w_wait_nx;
         r_ram_addr <= w_ram_addr_nx;
         r_ram_rd   <= w_ram_rd_nx;
         r_cnt      <= w_cnt_nx;
         r_overrun  <= w_overrun_nx;
         r_upload_d <= ioctl_upload;
      end
   end

   assign ioctl_din  = r_din;
   assign ioctl_wait = r_wait;
   assign ram_addr   = r_ram_addr;
   assign ram_rd     = r_ram_rd;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_upload_responder.sv
// Bench for upload_responder: two instances on one ioctl bus (window at 0x100
// with RAM latency 1, and a wrapping window at 0xFFE with RAM latency 2).
`timescale 1ns/1ps
module tb_upload_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        upload;
   logic [7:0]  index;
   logic        rd;
   logic [24:0] addr;
   logic        gnt;
   logic        sel_b;

   logic [7:0]  din_a, din_b;
   logic        wait_a, wait_b, ram_rd_a, ram_rd_b, ovr_a, ovr_b;
   logic [11:0] ram_addr_a, ram_addr_b;
   logic [7:0]  ram_q_a = 8'h00;
   logic [7:0]  s1_b    = 8'h00;
   logic [7:0]  ram_q_b = 8'h00;
   logic [7:0]  mem [0:4095];

   logic [7:0]  obs_din;
   logic        obs_wait, obs_ram_rd;
   logic [11:0] obs_ram_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   upload_responder #(.AW(12), .START_ADDR(12'h100), .LENGTH(64), .INDEX(8'd3), .RAM_LAT(1)) u_a (
      .clk(clk), .RESET_N(rst_n), .ioctl_upload(upload), .ioctl_index(index),
      .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din_a), .ioctl_wait(wait_a),
      .ram_addr(ram_addr_a), .ram_rd(ram_rd_a), .ram_grant(gnt), .ram_q(ram_q_a),
      .overrun(ovr_a));

   upload_responder #(.AW(12), .START_ADDR(12'hFFE), .LENGTH(4), .INDEX(8'd5), .RAM_LAT(2)) u_b (
      .clk(clk), .RESET_N(rst_n), .ioctl_upload(upload), .ioctl_index(index),
      .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din_b), .ioctl_wait(wait_b),
      .ram_addr(ram_addr_b), .ram_rd(ram_rd_b), .ram_grant(gnt), .ram_q(ram_q_b),
      .overrun(ovr_b));

   assign obs_din      = sel_b ? din_b      : din_a;
   assign obs_wait     = sel_b ? wait_b     : wait_a;
   assign obs_ram_rd   = sel_b ? ram_rd_b   : ram_rd_a;
   assign obs_ram_addr = sel_b ? ram_addr_b : ram_addr_a;

   // RAM with one cycle of read latency for instance A.
   always @(posedge clk) begin
      if (ram_rd_a && gnt) ram_q_a <= mem[ram_addr_a];
   end

   // RAM with two cycles of read latency for instance B.
   always @(posedge clk) begin
      if (ram_rd_b && gnt) s1_b <= mem[ram_addr_b];
      ram_q_b <= s1_b;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // One HPS strobe, then follow the fetch until wait drops, granting after 'delay' request cycles.
   task automatic xact(input logic [24:0] a, input logic [7:0] idx, input logic up, input int delay,
                       output logic [7:0] o_din, output int o_wait, output int o_rdc,
                       output logic [11:0] o_addr, output logic o_stable);
      int n;
      addr = a; index = idx; upload = up; rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0; upload = 1'b1;
      n = 0; o_rdc = 0; o_stable = 1'b1; o_addr = obs_ram_addr;
      while (obs_wait && n < 64) begin
         if (obs_ram_rd) begin
            if (obs_ram_addr !== o_addr) o_stable = 1'b0;
            gnt = (o_rdc == delay);
            o_rdc++;
         end else begin
            gnt = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      gnt = 1'b0;
      o_wait = n;
      o_din = obs_din;
   endtask

   typedef struct {
      logic [24:0] a;
      logic [7:0]  idx;
      logic        up;
      int          delay;
      logic [7:0]  exp_din;
      int          exp_wait;
      int          exp_rdc;
      logic [11:0] exp_addr;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [7:0]  g_din;
      int          g_wait, g_rdc;
      logic [11:0] g_addr, e_addr;
      logic        g_stable;
      logic [7:0]  model_din;
      logic [24:0] a;
      logic [7:0]  idx;
      logic        up;
      int          dly, e_wait, e_rdc;
      logic [7:0]  prev;

      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[12'h105] = 8'hA5;

      // entries: addr, index, upload, grant delay, din, wait cycles, ram_rd cycles, ram_addr
      vecs[0] = '{25'd5,        8'd3,   1'b1, 0, 8'hA5, 2, 1, 12'h105};
      vecs[1] = '{25'd64,       8'd3,   1'b1, 0, 8'hFF, 0, 0, 12'h000};
      vecs[2] = '{25'd2,        8'd2,   1'b1, 0, 8'hFF, 0, 0, 12'h000};
      vecs[3] = '{25'd63,       8'd3,   1'b1, 1, 8'h65, 3, 2, 12'h13F};
      vecs[4] = '{25'h1000010,  8'd3,   1'b1, 0, 8'hFF, 0, 0, 12'h000};
      vecs[5] = '{25'd0,        8'd3,   1'b0, 0, 8'hFF, 0, 0, 12'h000};
      vecs[6] = '{25'd0,        8'd3,   1'b1, 2, 8'h5A, 4, 3, 12'h100};
      vecs[7] = '{25'd7,        8'hFF,  1'b1, 0, 8'h5A, 0, 0, 12'h000};
      vecs[8] = '{25'd32,       8'd3,   1'b1, 0, 8'h7A, 2, 1, 12'h120};

      rst_n = 1'b0; upload = 1'b0; index = 8'd0; rd = 1'b0; addr = 25'd0; gnt = 1'b0; sel_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_din_a", din_a, 8'h00);
      chk("reset_wait_a", wait_a, 1'b0);
      chk("reset_ram_rd_a", ram_rd_a, 1'b0);
      chk("reset_overrun_a", ovr_a, 1'b0);
      chk("reset_din_b", din_b, 8'h00);
      chk("reset_wait_b", wait_b, 1'b0);
      chk("reset_ram_rd_b", ram_rd_b, 1'b0);
      chk("reset_overrun_b", ovr_b, 1'b0);
      rst_n = 1'b1; upload = 1'b1;
      @(posedge clk); #1;

      // Table-driven transactions on instance A.
      for (int i = 0; i < 9; i++) begin
         xact(vecs[i].a, vecs[i].idx, vecs[i].up, vecs[i].delay, g_din, g_wait, g_rdc, g_addr, g_stable);
         chk($sformatf("vec%0d_din", i), g_din, vecs[i].exp_din);
         chk($sformatf("vec%0d_wait_cycles", i), g_wait, vecs[i].exp_wait);
         chk($sformatf("vec%0d_rd_cycles", i), g_rdc, vecs[i].exp_rdc);
         if (vecs[i].exp_rdc > 0) begin
            chk($sformatf("vec%0d_ram_addr", i), g_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_addr_stable", i), g_stable, 1'b1);
         end
         @(posedge clk); #1;
      end
      model_din = 8'h7A;

      // Randomized transactions on instance A against the region/latency rules.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: a = 25'($urandom_range(0, 63));
            1: a = 25'($urandom_range(64, 300));
            default: a = 25'($urandom);
         endcase
         idx = ($urandom_range(0, 3) == 0) ? 8'd2 : 8'd3;
         up  = ($urandom_range(0, 7) != 0);
         dly = $urandom_range(0, 4);
         e_wait = 0; e_rdc = 0; e_addr = 12'h000;
         if (up && idx == 8'd3) begin
            if (a < 25'd64) begin
               e_addr    = 12'((32'h100 + 32'(a)) % 32'd4096);
               model_din = mem[e_addr];
               e_rdc     = dly + 1;
               e_wait    = dly + 1 + 1;
            end else begin
               model_din = 8'hFF;
            end
         end
         xact(a, idx, up, dly, g_din, g_wait, g_rdc, g_addr, g_stable);
         chk($sformatf("rnd%0d_din", i), g_din, model_din);
         chk($sformatf("rnd%0d_wait_cycles", i), g_wait, e_wait);
         chk($sformatf("rnd%0d_rd_cycles", i), g_rdc, e_rdc);
         if (e_rdc > 0) chk($sformatf("rnd%0d_ram_addr", i), g_addr, e_addr);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end
      chk("rnd_no_overrun", ovr_a, 1'b0);

      // Overrun during REQ, then abort by dropping upload during LAT.
      index = 8'd3; addr = 25'd10; rd = 1'b1;
      @(posedge clk); #1;
      chk("ovr_req_ram_rd", ram_rd_a, 1'b1);
      chk("ovr_req_ram_addr", ram_addr_a, 12'h10A);
      rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
      chk("ovr_set", ovr_a, 1'b1);
      chk("ovr_ram_rd_held", ram_rd_a, 1'b1);
      chk("ovr_ram_addr_held", ram_addr_a, 12'h10A);
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      chk("lat_ram_rd_low", ram_rd_a, 1'b0);
      chk("lat_wait_high", wait_a, 1'b1);
      prev = din_a;
      upload = 1'b0;
      @(posedge clk); #1;
      chk("abort_wait", wait_a, 1'b0);
      chk("abort_ram_rd", ram_rd_a, 1'b0);
      chk("abort_din_kept", din_a, prev);
      chk("abort_ovr_kept", ovr_a, 1'b1);
      @(posedge clk); #1;
      chk("no_rd_outside_session", ram_rd_a, 1'b0);
      // Strobe in the very cycle upload rises is accepted; the rise clears overrun.
      upload = 1'b1; addr = 25'd1; rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
      chk("rise_clears_ovr", ovr_a, 1'b0);
      chk("rise_strobe_wait", wait_a, 1'b1);
      chk("rise_strobe_addr", ram_addr_a, 12'h101);
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      @(posedge clk); #1;
      chk("rise_strobe_din", din_a, 8'h5B);
      chk("rise_strobe_wait_done", wait_a, 1'b0);

      // Instance B: wrapping window, delayed grant, RAM latency 2.
      sel_b = 1'b1;
      xact(25'd3, 8'd5, 1'b1, 2, g_din, g_wait, g_rdc, g_addr, g_stable);
      chk("wrap_ram_addr", g_addr, 12'h001);
      chk("wrap_rd_cycles", g_rdc, 3);
      chk("wrap_addr_stable", g_stable, 1'b1);
      chk("wrap_wait_cycles", g_wait, 5);
      chk("wrap_din", g_din, 8'h5B);
      xact(25'd4, 8'd5, 1'b1, 0, g_din, g_wait, g_rdc, g_addr, g_stable);
      chk("wrap_oor_din", g_din, 8'hFF);
      chk("wrap_oor_wait", g_wait, 0);
      chk("wrap_a_din_untouched", din_a, 8'h5B);
      sel_b = 1'b0;

      // Asynchronous reset in the middle of a pending request with overrun set.
      @(posedge clk); #1;
      index = 8'd3; addr = 25'd2; rd = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rd = 1'b0;
      chk("pre_reset_ovr", ovr_a, 1'b1);
      chk("pre_reset_wait", wait_a, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_wait", wait_a, 1'b0);
      chk("async_reset_ram_rd", ram_rd_a, 1'b0);
      chk("async_reset_din", din_a, 8'h00);
      chk("async_reset_ovr", ovr_a, 1'b0);
      #10;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/upload_responder.md
Name: upload_responder

Overview:
- Serves HPS upload (save) reads for a core RAM region, such as the hiscore or NVRAM area.
- HPS pulses ioctl_rd with an address. The block fetches the byte through an arbitrated core-RAM read port and returns it on ioctl_din.
- ioctl_wait stalls the HPS until the byte is valid.
- Sits beside the hiscore writer in emu, on the same ioctl bus, and is the read-side counterpart of the ioctl download path.

Parameters:
AW, 12, core RAM address width.
START_ADDR, 12'h000, first RAM address of the region (AW bits).
LENGTH, 64, region size in bytes (1..2^AW).
INDEX, 8'd3, ioctl_index value this block answers.
RAM_LAT, 1, cycles from accepted ram_rd to valid ram_q (1..4).

Ports:
clk  in  1  system clock (clk_sys)
RESET_N  in  1  asynchronous active-low reset
ioctl_upload  in  1  HPS upload session active
ioctl_index  in  8  upload target index
ioctl_rd  in  1  one-cycle read strobe from HPS
ioctl_addr  in  25  byte offset of the read
ioctl_din  out  8  read data to HPS
ioctl_wait  out  1  stall HPS; data not yet valid
ram_addr  out  AW  core RAM read address
ram_rd  out  1  RAM read request, held until granted
ram_grant  in  1  core arbiter accepts the request this cycle
ram_q  in  8  RAM read data
overrun  out  1  sticky: ioctl_rd arrived while busy

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0; state IDLE. This includes ioctl_din=8'h00, ioctl_wait=0, ram_rd=0 and overrun=0.
- A strobe is "selected" when ioctl_rd=1, ioctl_upload=1 and ioctl_index==INDEX. Non-selected strobes are ignored; no output changes.
- State IDLE, selected strobe with ioctl_addr >= LENGTH (compare in full 25-bit width):
  - Next cycle, ioctl_din=8'hFF.
  - ioctl_wait stays 0.
  - State remains IDLE.
- State IDLE, selected strobe with ioctl_addr < LENGTH:
  - Next cycle, ioctl_wait=1.
  - ram_addr = START_ADDR + ioctl_addr[AW-1:0], truncated to AW bits (wraps modulo 2^AW).
  - ram_rd=1; go to REQ.
- State REQ:
  - ram_rd and ram_addr are held stable until a cycle with ram_grant=1. That cycle is the acceptance.
  - On acceptance, the next cycle has ram_rd=0, the latency counter is loaded with RAM_LAT-1, and the state goes to LAT.
  - The grant may already be high in the first REQ cycle, giving one-cycle acceptance.
- State LAT:
  - The counter decrements each cycle.
  - When the counter is 0, ram_q is captured into ioctl_din and ioctl_wait drops to 0 in the same edge; return to IDLE.
  - Minimum latency: data valid and wait low RAM_LAT+1 cycles after the accepted cycle, when the grant is immediate.
- ioctl_din holds its value until the next selected strobe completes. It does not change on ignored strobes.
- Selected strobe while not IDLE:
  - The strobe is ignored and overrun is set to 1.
  - overrun stays 1 until reset or the rising edge of ioctl_upload.
- ioctl_upload falling while in REQ or LAT (abort):
  - Next cycle, state is IDLE, ram_rd=0 and ioctl_wait=0.
  - ioctl_din is unchanged; the in-flight ram_q is discarded.
- ioctl_upload rising: clears overrun. Data and state are unaffected.
- Strobe in the same cycle as ioctl_upload rises: accepted normally, since selection uses the current ioctl_upload level.
- No ram_rd is ever issued outside an upload session.

Decomposition:
- Shared package (ioctl_pkg): upload state enum (IDLE, REQ, LAT), the fill constant 8'hFF, and the ioctl address width constant 25.
- No sub-module; the latency counter is inline.

Test Plan:
- Basic read, RAM_LAT=1, grant tied 1, START_ADDR=12'h100, RAM[0x105]=8'hA5:
  - Stimulus: strobe with addr 5.
  - Response: ram_addr=0x105; ioctl_wait high for exactly 2 cycles; then ioctl_din=8'hA5, wait=0.
- Grant delayed 3 cycles, RAM_LAT=2:
  - Response: ram_rd held 3 cycles with constant ram_addr; wait deasserts 3 cycles after acceptance; correct byte returned.
- Out-of-range and wrong index, LENGTH=64:
  - Strobe with addr 64: response ioctl_din=8'hFF next cycle, no wait, no ram_rd.
  - Strobe with index 2: no change.
- Wrap-around:
  - Stimulus: START_ADDR=12'hFFE, LENGTH=4, addr 3.
  - Response: ram_addr=12'h001.
- Overrun and abort:
  - Second strobe during REQ: response overrun=1.
  - Drop ioctl_upload during LAT: response next cycle wait=0, ram_rd=0, ioctl_din unchanged.
  - New upload rising edge: overrun clears.
- Async reset mid-REQ:
  - Stimulus: RESET_N low between clock edges.
  - Response: immediately ioctl_wait=0, ram_rd=0, ioctl_din=0, overrun=0.
